// File: rtl/pipelined_controller_pkg.sv
// Shared encodings for the MIPS pipeline controller: opcode/func codes, ALU codes,
// memory-size and branch encodings, and the per-stage control bundle layout.
package pipelined_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam int ALU_CODE_W = 4;
    localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_ADDU = 4'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_CODE_W-1:0] ALU_NOR  = 4'd5;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 4'd6;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 4'd7;
    localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 4'd8;
    localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 4'd9;
    localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 4'd10;
    localparam logic [ALU_CODE_W-1:0] ALU_SUBU = 4'd11;
    localparam logic [ALU_CODE_W-1:0] ALU_LUI  = 4'd12;

    localparam int SIZE_W = 2;
    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;

    localparam int BR_W = 2;
    localparam logic [BR_W-1:0] BR_NONE = 2'b00;
    localparam logic [BR_W-1:0] BR_BEQ  = 2'b01;
    localparam logic [BR_W-1:0] BR_BNE  = 2'b10;

    typedef struct packed {
        logic [ALU_CODE_W-1:0] aluop;
        logic                  alusrc;
        logic                  shift;
        logic [BR_W-1:0]       branch;
        logic                  jr;
    } ex_ctrl_t;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [SIZE_W-1:0] size;
    } mem_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    typedef struct packed {
        logic      illegal;
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // ALU operation for the I-type arithmetic/logic group.
    function automatic logic [ALU_CODE_W-1:0] imm_aluop(input logic [5:0] op);
        case (op)
            OP_ADDI:  return ALU_ADD;
            OP_ADDIU: return ALU_ADDU;
            OP_SLTI:  return ALU_SLT;
            OP_SLTIU: return ALU_SLTU;
            OP_ANDI:  return ALU_AND;
            OP_ORI:   return ALU_OR;
            OP_LUI:   return ALU_LUI;
            default:  return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/pipelined_controller_decode.sv
// Pure combinational opcode/func decoder producing the control bundle, the
// destination register and which source registers the instruction reads.
module control_decode
    import pipelined_controller_pkg::*;
#(
    parameter int RADDR_W = 5
) (
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic [RADDR_W-1:0] rt,
    input  logic [RADDR_W-1:0] rd,
    output logic [CTRL_W-1:0]  ctrl_bits,
    output logic [RADDR_W-1:0] waddr,
    output logic               use_rs,
    output logic               use_rt
);

    ctrl_t              c;
    logic [RADDR_W-1:0] wa;

    always_comb begin
        c         = '0;
        c.ex.branch = BR_NONE;
        wa        = '0;
        use_rs    = 1'b0;
        use_rt    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                use_rs        = 1'b1;
                use_rt        = 1'b1;
                wa            = rd;
                c.wb.regwrite = 1'b1;
                case (func)
                    FN_ADD:  c.ex.aluop = ALU_ADD;
                    FN_ADDU: c.ex.aluop = ALU_ADDU;
                    FN_SUB:  c.ex.aluop = ALU_SUB;
                    FN_SUBU: c.ex.aluop = ALU_SUBU;
                    FN_AND:  c.ex.aluop = ALU_AND;
                    FN_OR:   c.ex.aluop = ALU_OR;
                    FN_NOR:  c.ex.aluop = ALU_NOR;
                    FN_SLT:  c.ex.aluop = ALU_SLT;
                    FN_SLL: begin
                        c.ex.aluop = ALU_SLL;
                        c.ex.shift = 1'b1;
                        use_rs     = 1'b0;
                    end
                    FN_SRL: begin
                        c.ex.aluop = ALU_SRL;
                        c.ex.shift = 1'b1;
                        use_rs     = 1'b0;
                    end
                    FN_SRA: begin
                        c.ex.aluop = ALU_SRA;
                        c.ex.shift = 1'b1;
                        use_rs     = 1'b0;
                    end
                    FN_JR: begin
                        c.ex.jr       = 1'b1;
                        c.wb.regwrite = 1'b0;
                        wa            = '0;
                    end
                    default: begin
                        c         = '0;
                        c.illegal = 1'b1;
                        wa        = '0;
                        use_rs    = 1'b0;
                        use_rt    = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI: begin
                c.ex.alusrc   = 1'b1;
                c.ex.aluop    = imm_aluop(opcode);
                c.wb.regwrite = 1'b1;
                wa            = rt;
                use_rs        = (opcode != OP_LUI);
            end
            OP_LW, OP_LHU, OP_LBU: begin
                c.ex.alusrc   = 1'b1;
                c.ex.aluop    = ALU_ADD;
                c.mem.read    = 1'b1;
                c.wb.memtoreg = 1'b1;
                c.wb.regwrite = 1'b1;
                wa            = rt;
                use_rs        = 1'b1;
                c.mem.size    = (opcode == OP_LW)  ? SIZE_WORD :
                                (opcode == OP_LHU) ? SIZE_HALF : SIZE_BYTE;
            end
            OP_SW, OP_SH, OP_SB: begin
                c.ex.alusrc = 1'b1;
                c.ex.aluop  = ALU_ADD;
                c.mem.write = 1'b1;
                use_rs      = 1'b1;
                use_rt      = 1'b1;
                c.mem.size  = (opcode == OP_SW) ? SIZE_WORD :
                              (opcode == OP_SH) ? SIZE_HALF : SIZE_BYTE;
            end
            OP_BEQ, OP_BNE: begin
                c.ex.aluop  = ALU_SUB;
                c.ex.branch = (opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
                use_rs      = 1'b1;
                use_rt      = 1'b1;
            end
            default: begin
                c.illegal = 1'b1;
            end
        endcase
        // $zero is never a real destination.
        if (wa == '0) c.wb.regwrite = 1'b0;
    end

    assign ctrl_bits = c;
    assign waddr     = wa;

endmodule

// File: rtl/pipelined_controller.sv
// MIPS 5-stage pipeline control: ID decode, ID/EX -> EX/MEM -> MEM/WB control
// registers, load-use stall FSM with configurable bubble count, and EX-redirect flush.
module pipelined_controller
    import pipelined_controller_pkg::*;
#(
    parameter int ALUOP_W        = 4,
    parameter int RADDR_W        = 5,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               id_valid,
    input  logic [5:0]         id_opcode,
    input  logic [5:0]         id_func,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               ex_redirect,
    output logic               stall,
    output logic               flush,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_alusrc,
    output logic               ex_shift,
    output logic [1:0]         ex_branch,
    output logic               ex_jr,
    output logic               mem_read,
    output logic               mem_write,
    output logic [1:0]         mem_size,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic [RADDR_W-1:0] wb_waddr,
    output logic               illegal
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;
    localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_STALL - 1);

    logic [CTRL_W-1:0]  dec_bits;
    ctrl_t              dec_ctrl;
    logic [RADDR_W-1:0] dec_waddr;
    logic               use_rs;
    logic               use_rt;

    logic [0:0]         state, state_nxt;
    logic [1:0]         cnt, cnt_nxt;
    logic               stall_c;
    logic               bubble;
    logic               hazard;
    logic               holding;

    ctrl_t              ctrl_p0;
    logic [RADDR_W-1:0] waddr_p0;
    logic               vld_p0;
    mem_ctrl_t          mem_p1;
    wb_ctrl_t           wb_p1;
    logic [RADDR_W-1:0] waddr_p1;
    logic               vld_p1;
    wb_ctrl_t           wb_p2;
    logic [RADDR_W-1:0] waddr_p2;
    logic               vld_p2;

    control_decode #(.RADDR_W(RADDR_W)) u_decode (
        .opcode    (id_opcode),
        .func      (id_func),
        .rt        (id_rt),
        .rd        (id_rd),
        .ctrl_bits (dec_bits),
        .waddr     (dec_waddr),
        .use_rs    (use_rs),
        .use_rt    (use_rt)
    );

    assign dec_ctrl = ctrl_t'(dec_bits);

    assign hazard = id_valid && vld_p0 && ctrl_p0.mem.read && (waddr_p0 != '0) &&
                    ((use_rs && (id_rs == waddr_p0)) || (use_rt && (id_rt == waddr_p0)));

    // A STALL cycle with cnt==0 is the release cycle and behaves like RUN.
    assign holding = (state == ST_STALL) && (cnt != 2'd0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_c   = 1'b0;
        bubble    = !id_valid;
        if (ex_redirect) begin
            state_nxt = ST_RUN;
            cnt_nxt   = 2'd0;
            bubble    = 1'b1;
        end else if (holding) begin
            stall_c = 1'b1;
            bubble  = 1'b1;
            cnt_nxt = cnt - 2'd1;
        end else if (hazard) begin
            stall_c   = 1'b1;
            bubble    = 1'b1;
            state_nxt = ST_STALL;
            cnt_nxt   = CNT_INIT;
        end else begin
            state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_RUN;
            cnt      <= 2'd0;
            ctrl_p0  <= '0;
            waddr_p0 <= '0;
            vld_p0   <= 1'b0;
            mem_p1   <= '0;
            wb_p1    <= '0;
            waddr_p1 <= '0;
            vld_p1   <= 1'b0;
            wb_p2    <= '0;
            waddr_p2 <= '0;
            vld_p2   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // ID -> EX
            if (bubble) begin
                ctrl_p0  <= '0;
                waddr_p0 <= '0;
                vld_p0   <= 1'b0;
            end else begin
                ctrl_p0  <= dec_ctrl;
                waddr_p0 <= dec_waddr;
                vld_p0   <= 1'b1;
            end
            // EX -> MEM
            mem_p1   <= ctrl_p0.mem;
            wb_p1    <= ctrl_p0.wb;
            waddr_p1 <= waddr_p0;
            vld_p1   <= vld_p0;
            // MEM -> WB
            wb_p2    <= wb_p1;
            waddr_p2 <= waddr_p1;
            vld_p2   <= vld_p1;
        end
    end

    assign stall       = stall_c;
    assign flush       = ex_redirect;
    assign ex_aluop    = ALUOP_W'(ctrl_p0.ex.aluop);
    assign ex_alusrc   = ctrl_p0.ex.alusrc;
    assign ex_shift    = ctrl_p0.ex.shift;
    assign ex_branch   = ctrl_p0.ex.branch;
    assign ex_jr       = ctrl_p0.ex.jr;
    assign illegal     = ctrl_p0.illegal & vld_p0;
    assign mem_read    = mem_p1.read & vld_p1;
    assign mem_write   = mem_p1.write & vld_p1;
    assign mem_size    = mem_p1.size;
    assign wb_regwrite = wb_p2.regwrite & vld_p2;
    assign wb_memtoreg = wb_p2.memtoreg;
    assign wb_waddr    = waddr_p2;

endmodule

// File: tb/tb_pipelined_controller.sv
// Directed bench for pipelined_controller (LOAD_USE_STALL=2) with an
// expectation queue keyed by the cycle in which each output must show the value.
module tb_pipelined_controller;
    import pipelined_controller_pkg::*;

    localparam int K_STALL = 0, K_FLUSH = 1, K_ALUOP = 2, K_ALUSRC = 3, K_SHIFT = 4,
                   K_BRANCH = 5, K_JR = 6, K_MREAD = 7, K_MWRITE = 8, K_MSIZE = 9,
                   K_REGWR = 10, K_MEMTOREG = 11, K_WADDR = 12, K_ILLEGAL = 13;
    localparam int K_LAST = 13;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid;
    logic [5:0] id_opcode, id_func;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_redirect;
    logic       stall, flush, ex_alusrc, ex_shift, ex_jr, mem_read, mem_write;
    logic       wb_regwrite, wb_memtoreg, illegal;
    logic [3:0] ex_aluop;
    logic [1:0] ex_branch, mem_size;
    logic [4:0] wb_waddr;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    pipelined_controller #(.ALUOP_W(4), .RADDR_W(5), .LOAD_USE_STALL(2)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_func(id_func), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_redirect(ex_redirect), .stall(stall), .flush(flush), .ex_aluop(ex_aluop),
        .ex_alusrc(ex_alusrc), .ex_shift(ex_shift), .ex_branch(ex_branch), .ex_jr(ex_jr),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_waddr(wb_waddr),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs(input int k);
        case (k)
            K_STALL:    return 32'(stall);
            K_FLUSH:    return 32'(flush);
            K_ALUOP:    return 32'(ex_aluop);
            K_ALUSRC:   return 32'(ex_alusrc);
            K_SHIFT:    return 32'(ex_shift);
            K_BRANCH:   return 32'(ex_branch);
            K_JR:       return 32'(ex_jr);
            K_MREAD:    return 32'(mem_read);
            K_MWRITE:   return 32'(mem_write);
            K_MSIZE:    return 32'(mem_size);
            K_REGWR:    return 32'(wb_regwrite);
            K_MEMTOREG: return 32'(wb_memtoreg);
            K_WADDR:    return 32'(wb_waddr);
            default:    return 32'(illegal);
        endcase
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_STALL:    return "stall";
            K_FLUSH:    return "flush";
            K_ALUOP:    return "ex_aluop";
            K_ALUSRC:   return "ex_alusrc";
            K_SHIFT:    return "ex_shift";
            K_BRANCH:   return "ex_branch";
            K_JR:       return "ex_jr";
            K_MREAD:    return "mem_read";
            K_MWRITE:   return "mem_write";
            K_MSIZE:    return "mem_size";
            K_REGWR:    return "wb_regwrite";
            K_MEMTOREG: return "wb_memtoreg";
            K_WADDR:    return "wb_waddr";
            default:    return "illegal";
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic push(input int d, input int k, input logic [31:0] v);
        exp_t e;
        e.due  = d;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic exp_ctl(input int d, input logic s, input logic f);
        push(d, K_STALL, 32'(s));
        push(d, K_FLUSH, 32'(f));
    endtask

    task automatic exp_ex(input int d, input logic [3:0] op, input logic src,
                          input logic sh, input logic [1:0] br, input logic jr);
        push(d, K_ALUOP, 32'(op));
        push(d, K_ALUSRC, 32'(src));
        push(d, K_SHIFT, 32'(sh));
        push(d, K_BRANCH, 32'(br));
        push(d, K_JR, 32'(jr));
    endtask

    task automatic exp_mem(input int d, input logic rd, input logic wr, input logic [1:0] sz);
        push(d, K_MREAD, 32'(rd));
        push(d, K_MWRITE, 32'(wr));
        push(d, K_MSIZE, 32'(sz));
    endtask

    task automatic exp_wb(input int d, input logic rw, input logic m2r, input logic [4:0] wa);
        push(d, K_REGWR, 32'(rw));
        push(d, K_MEMTOREG, 32'(m2r));
        push(d, K_WADDR, 32'(wa));
    endtask

    // Compare everything due this cycle at the falling edge, then advance one cycle.
    task automatic tick();
        int i;
        @(negedge clk);
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                chk($sformatf("%s@%0d", kname(sb[i].kind), cyc), obs(sb[i].kind), sb[i].val);
                sb.delete(i);
            end else begin
                i++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic redir);
        id_valid    = v;
        id_opcode   = op;
        id_func     = fn;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        ex_redirect = redir;
    endtask

    task automatic idle();
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k <= K_LAST; k++) chk($sformatf("%s_%s", tag, kname(k)), obs(k), 32'd0);
    endtask

    // LW $5,0($1) in the current cycle, with its full downstream expectations.
    task automatic issue_lw5();
        drive(1'b1, OP_LW, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);
        exp_ctl(cyc, 1'b0, 1'b0);
        exp_ex(cyc + 1, ALU_ADD, 1'b1, 1'b0, BR_NONE, 1'b0);
        exp_mem(cyc + 2, 1'b1, 1'b0, SIZE_WORD);
        exp_wb(cyc + 3, 1'b1, 1'b1, 5'd5);
    endtask

    initial begin
        int a;
        reset_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;

        // Independent instructions, one per cycle.
        drive(1'b1, OP_RTYPE, FN_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
        exp_ctl(cyc, 1'b0, 1'b0);
        exp_ex(cyc + 1, ALU_ADD, 1'b0, 1'b0, BR_NONE, 1'b0);
        push(cyc + 1, K_ILLEGAL, 32'd0);
        exp_mem(cyc + 2, 1'b0, 1'b0, SIZE_BYTE);
        exp_wb(cyc + 3, 1'b1, 1'b0, 5'd3);
        tick();
        drive(1'b1, OP_RTYPE, FN_SLL, 5'd0, 5'd2, 5'd4, 1'b0);
        exp_ex(cyc + 1, ALU_SLL, 1'b0, 1'b1, BR_NONE, 1'b0);
        exp_wb(cyc + 3, 1'b1, 1'b0, 5'd4);
        tick();
        drive(1'b1, OP_ORI, 6'h00, 5'd1, 5'd7, 5'd0, 1'b0);
        exp_ex(cyc + 1, ALU_OR, 1'b1, 1'b0, BR_NONE, 1'b0);
        exp_wb(cyc + 3, 1'b1, 1'b0, 5'd7);
        tick();
        drive(1'b1, OP_ADDI, 6'h00, 5'd1, 5'd0, 5'd0, 1'b0);
        exp_ex(cyc + 1, ALU_ADD, 1'b1, 1'b0, BR_NONE, 1'b0);
        exp_wb(cyc + 3, 1'b0, 1'b0, 5'd0);
        tick();
        drive(1'b1, OP_SB, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
        exp_mem(cyc + 2, 1'b0, 1'b1, SIZE_BYTE);
        exp_wb(cyc + 3, 1'b0, 1'b0, 5'd0);
        tick();
        drive(1'b1, OP_LHU, 6'h00, 5'd2, 5'd8, 5'd0, 1'b0);
        exp_mem(cyc + 2, 1'b1, 1'b0, SIZE_HALF);
        exp_wb(cyc + 3, 1'b1, 1'b1, 5'd8);
        tick();
        drive(1'b1, OP_BNE, 6'h00, 5'd3, 5'd4, 5'd0, 1'b0);
        exp_ctl(cyc, 1'b0, 1'b0);
        exp_ex(cyc + 1, ALU_SUB, 1'b0, 1'b0, BR_BNE, 1'b0);
        exp_wb(cyc + 3, 1'b0, 1'b0, 5'd0);
        tick();
        drive(1'b1, OP_RTYPE, FN_JR, 5'd31, 5'd0, 5'd0, 1'b0);
        exp_ex(cyc + 1, ALU_AND, 1'b0, 1'b0, BR_NONE, 1'b1);
        exp_wb(cyc + 3, 1'b0, 1'b0, 5'd0);
        tick();
        idle();
        exp_ex(cyc + 1, 4'd0, 1'b0, 1'b0, BR_NONE, 1'b0);
        repeat (4) tick();

        // Load-use: two bubbles, ADD reaches EX three cycles after the stall starts.
        a = cyc;
        issue_lw5();
        tick();
        drive(1'b1, OP_RTYPE, FN_ADD, 5'd5, 5'd1, 5'd6, 1'b0);
        exp_ctl(a + 1, 1'b1, 1'b0);
        exp_ctl(a + 2, 1'b1, 1'b0);
        exp_ctl(a + 3, 1'b0, 1'b0);
        exp_ex(a + 2, 4'd0, 1'b0, 1'b0, BR_NONE, 1'b0);
        exp_ex(a + 3, 4'd0, 1'b0, 1'b0, BR_NONE, 1'b0);
        exp_ex(a + 4, ALU_ADD, 1'b0, 1'b0, BR_NONE, 1'b0);
        exp_mem(a + 3, 1'b0, 1'b0, SIZE_BYTE);
        exp_wb(a + 4, 1'b0, 1'b0, 5'd0);
        exp_wb(a + 5, 1'b0, 1'b0, 5'd0);
        exp_wb(a + 6, 1'b1, 1'b0, 5'd6);
        repeat (3) tick();
        idle();
        repeat (4) tick();

        // Redirect during the would-be first stall cycle: flush wins, no stall.
        a = cyc;
        issue_lw5();
        tick();
        drive(1'b1, OP_RTYPE, FN_ADD, 5'd5, 5'd1, 5'd6, 1'b1);
        exp_ctl(a + 1, 1'b0, 1'b1);
        exp_ex(a + 2, 4'd0, 1'b0, 1'b0, BR_NONE, 1'b0);
        tick();
        drive(1'b1, OP_RTYPE, FN_ADD, 5'd5, 5'd1, 5'd6, 1'b0);
        exp_ctl(a + 2, 1'b0, 1'b0);
        exp_ex(a + 3, ALU_ADD, 1'b0, 1'b0, BR_NONE, 1'b0);
        exp_wb(a + 5, 1'b1, 1'b0, 5'd6);
        tick();
        idle();
        repeat (4) tick();

        // Illegal opcode, then illegal R-type func: one-cycle pulses, no other controls.
        a = cyc;
        drive(1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0);
        exp_ctl(a, 1'b0, 1'b0);
        push(a + 1, K_ILLEGAL, 32'd1);
        exp_ex(a + 1, 4'd0, 1'b0, 1'b0, BR_NONE, 1'b0);
        exp_mem(a + 2, 1'b0, 1'b0, SIZE_BYTE);
        exp_wb(a + 3, 1'b0, 1'b0, 5'd0);
        tick();
        drive(1'b1, OP_RTYPE, 6'h3F, 5'd1, 5'd2, 5'd9, 1'b0);
        push(a + 2, K_ILLEGAL, 32'd1);
        exp_ex(a + 2, 4'd0, 1'b0, 1'b0, BR_NONE, 1'b0);
        exp_wb(a + 4, 1'b0, 1'b0, 5'd0);
        tick();
        idle();
        push(a + 3, K_ILLEGAL, 32'd0);
        repeat (4) tick();

        // Asynchronous reset in the middle of a stall.
        a = cyc;
        drive(1'b1, OP_LW, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);
        exp_ctl(a, 1'b0, 1'b0);
        tick();
        drive(1'b1, OP_RTYPE, FN_ADD, 5'd5, 5'd1, 5'd6, 1'b0);
        exp_ctl(a + 1, 1'b1, 1'b0);
        tick();
        #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        chk("pre_rst_mem_read", 32'(mem_read), 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        idle();
        #2;
        reset_n = 1'b1;
        tick();
        a = cyc;
        issue_lw5();
        tick();
        drive(1'b1, OP_RTYPE, FN_ADD, 5'd5, 5'd1, 5'd6, 1'b0);
        exp_ctl(a + 1, 1'b1, 1'b0);
        exp_ctl(a + 2, 1'b1, 1'b0);
        exp_ctl(a + 3, 1'b0, 1'b0);
        exp_ex(a + 3, 4'd0, 1'b0, 1'b0, BR_NONE, 1'b0);
        exp_ex(a + 4, ALU_ADD, 1'b0, 1'b0, BR_NONE, 1'b0);
        exp_wb(a + 6, 1'b1, 1'b0, 5'd6);
        repeat (3) tick();
        idle();
        repeat (5) tick();

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
